app_stream_injector: RTL

- Synthesizable, multi-channel successor to the simulation-only application injector.
- Accepts NUM_CH independent flit streams, each carrying task-descriptor and binary packets produced upstream, and buffers each in its own FIFO.
- Releases each packet only once its channel's start time in milliseconds has been reached.
- Arbitrates round-robin, packet-atomically, onto a single tx/credit flit port toward the NoC injection router.

---
 rtl/app_stream_injector_if.sv | 40 ++++
 rtl/app_stream_injector.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/app_stream_injector_if.sv
`default_nettype none
// ============================================================================
//  Module      : app_stream_injector_if
//  Description : Bundle of the injector's channel-side and NoC-side signals.
//                "master" is the side that feeds channels and returns credit.
//                "slave" is the injector itself.
//  Ports       : ch_valid_i/ch_ready_o/ch_data_i/ch_last_i/ch_start_i/ch_eoa_i
//                (per-channel input streams); tx_o/credit_i/data_o/grant_o/eoa_o
//                (single output flit port)
//  Revision    : 1.0 - initial release
// ============================================================================
interface app_stream_injector_if #(
    parameter int FLIT_SIZE = 32,
    parameter int NUM_CH    = 4
);
    localparam int GRANT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]           ch_valid_i;
    logic [NUM_CH-1:0]           ch_ready_o;
    logic [NUM_CH*FLIT_SIZE-1:0] ch_data_i;
    logic [NUM_CH-1:0]           ch_last_i;
    logic [NUM_CH*32-1:0]        ch_start_i;
    logic [NUM_CH-1:0]           ch_eoa_i;
    logic                        tx_o;
    logic                        credit_i;
    logic [FLIT_SIZE-1:0]        data_o;
    logic [GRANT_W-1:0]          grant_o;
    logic                        eoa_o;

    modport master (
        output ch_valid_i, ch_data_i, ch_last_i, ch_start_i, ch_eoa_i, credit_i,
        input  ch_ready_o, tx_o, data_o, grant_o, eoa_o
    );

    modport slave (
        input  ch_valid_i, ch_data_i, ch_last_i, ch_start_i, ch_eoa_i, credit_i,
        output ch_ready_o, tx_o, data_o, grant_o, eoa_o
    );
endinterface
`default_nettype wire

// File: rtl/app_stream_injector.sv
`default_nettype none
// ============================================================================
//  Module      : app_stream_injector
//  Description : Multi-channel application injector. Buffers NUM_CH flit
//                streams in per-channel FIFOs, holds each channel until its
//                millisecond start time is reached, then forwards whole
//                packets round-robin onto one tx/credit flit port.
//                Optional macro INJECTOR_TIMESTAMP_EN prepends a flit holding
//                the millisecond count captured at grant to every packet.
//  Ports       : clk_i   - clock
//                rst_ni  - asynchronous active-low reset
//                bus     - app_stream_injector_if.slave (channel inputs,
//                          output flit port, grant and end-of-applications)
//  Revision    : 1.0 - initial release
// ============================================================================
module app_stream_injector #(
    parameter int FLIT_SIZE  = 32,
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int MS_DIV     = 100
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    app_stream_injector_if.slave  bus
);
    localparam int GRANT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int PS_W    = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam int ENTRY_W = FLIT_SIZE + 1;
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(MS_DIV - 1);
    localparam logic [GRANT_W-1:0] RR_INIT = GRANT_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1
`ifdef INJECTOR_TIMESTAMP_EN
        , S_STAMP = 2'd2
`endif
    } state_t;

    // ------------------------------------------------------------------
    // Millisecond timebase; ms count saturates instead of wrapping so a
    // very late start time can never be released early.
    // ------------------------------------------------------------------
    logic [PS_W-1:0] r_ps;
    logic [31:0]     r_ms;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ps <= '0;
            r_ms <= '0;
        end else if (r_ps == PS_LAST) begin
            r_ps <= '0;
            if (r_ms != 32'hFFFF_FFFF) begin
                r_ms <= r_ms + 32'd1;
            end
        end else begin
            r_ps <= r_ps + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel FIFOs, entry = {last, data}
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0]  w_push;
    logic [NUM_CH-1:0]  w_pop;
    logic [NUM_CH-1:0]  w_empty;
    logic [NUM_CH-1:0]  w_full;
    logic [NUM_CH-1:0]  w_elig;
    logic [ENTRY_W-1:0] w_head [NUM_CH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
        logic [PTR_W-1:0]   r_wr;
        logic [PTR_W-1:0]   r_rd;
        logic [PTR_W:0]     r_cnt;

        assign w_full[c]  = (r_cnt == FULL_CNT);
        assign w_empty[c] = (r_cnt == '0);
        // Ready depends only on the stored count: a full FIFO refuses a
        // push even in a cycle where the head is being popped.
        assign w_push[c]  = bus.ch_valid_i[c] && !w_full[c];
        assign w_head[c]  = r_mem[r_rd];
        assign w_elig[c]  = !w_empty[c] && (r_ms >= bus.ch_start_i[c*32 +: 32]);

        always_ff @(posedge clk_i) begin
            if (w_push[c]) begin
                r_mem[r_wr] <= {bus.ch_last_i[c], bus.ch_data_i[c*FLIT_SIZE +: FLIT_SIZE]};
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_wr  <= '0;
                r_rd  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push[c]) begin
                    r_wr <= r_wr + 1'b1;
                end
                if (w_pop[c]) begin
                    r_rd <= r_rd + 1'b1;
                end
                case ({w_push[c], w_pop[c]})
                    2'b10:   r_cnt <= r_cnt + 1'b1;
                    2'b01:   r_cnt <= r_cnt - 1'b1;
                    default: r_cnt <= r_cnt;
                endcase
            end
        end
    end

    assign bus.ch_ready_o = ~w_full;

    // ------------------------------------------------------------------
    // Round-robin search starting just after the last packet's owner
    // ------------------------------------------------------------------
    logic               w_found;
    logic [GRANT_W-1:0] w_pick;
    logic [GRANT_W-1:0] w_cand;
    logic [GRANT_W-1:0] r_rr;

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            w_cand = GRANT_W'((int'(r_rr) + i) % NUM_CH);
            if (!w_found && w_elig[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    // ------------------------------------------------------------------
    // Packet FSM
    // ------------------------------------------------------------------
    state_t               r_state;
    state_t               w_state_d;
    logic [GRANT_W-1:0]   r_grant;
    logic [GRANT_W-1:0]   w_grant_d;
    logic [GRANT_W-1:0]   w_rr_d;
    logic [31:0]          r_stamp;
    logic [31:0]          w_stamp_d;
    logic                 w_tx;
    logic [FLIT_SIZE-1:0] w_data;
    logic [ENTRY_W-1:0]   w_head_g;
    logic                 r_eoa;

    assign w_head_g = w_head[r_grant];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_rr    <= RR_INIT;
            r_stamp <= '0;
        end else begin
            r_state <= w_state_d;
            r_grant <= w_grant_d;
            r_rr    <= w_rr_d;
            r_stamp <= w_stamp_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_grant_d = r_grant;
        w_rr_d    = r_rr;
        w_stamp_d = r_stamp;
        w_tx      = 1'b0;
        w_data    = '0;
        w_pop     = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant_d = w_pick;
                    w_stamp_d = r_ms;
`ifdef INJECTOR_TIMESTAMP_EN
                    w_state_d = S_STAMP;
`else
                    w_state_d = S_STREAM;
`endif
                end
            end
`ifdef INJECTOR_TIMESTAMP_EN
            S_STAMP: begin
                w_tx   = 1'b1;
                w_data = FLIT_SIZE'(r_stamp);
                if (bus.credit_i) begin
                    w_state_d = S_STREAM;
                end
            end
`endif
            S_STREAM: begin
                // Underflow gives a bubble, but the grant is kept so the
                // packet is never interleaved with another channel.
                w_tx = !w_empty[r_grant];
                if (w_tx) begin
                    w_data = w_head_g[FLIT_SIZE-1:0];
                    if (bus.credit_i) begin
                        w_pop[r_grant] = 1'b1;
                        if (w_head_g[FLIT_SIZE]) begin
                            w_rr_d    = r_grant;
                            w_state_d = S_IDLE;
                        end
                    end
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    // End-of-applications is sticky until reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_eoa <= 1'b0;
        end else if ((&bus.ch_eoa_i) && (&w_empty) && (r_state == S_IDLE)) begin
            r_eoa <= 1'b1;
        end
    end

    assign bus.tx_o    = w_tx;
    assign bus.data_o  = w_data;
    assign bus.grant_o = r_grant;
    assign bus.eoa_o   = r_eoa;

endmodule
`default_nettype wire
